fp32_sub_seq: RTL and testbench
===============================

// Module: fp32_sub_seq
// PURPOSE
// - Multi-cycle IEEE-754 single-precision subtractor: out = a - b.
// - Datapath works like the combinational FP32 adder: hidden-1 mantissas, right-shift align, truncation, leading-one normalise.
// - Alignment and normalisation are iterative, one bit per cycle, behind valid/ready handshakes on both sides.
// - Sits between the FPU operand issue stage and the result writeback/scoreboard.
// PARAMETERS
// - ALIGN_CLAMP  25  saturation of the alignment shift count; any exponent difference >= ALIGN_CLAMP zeroes the smaller mantissa.
// PORTS
// - clk        in   1   rising-edge clock
// - rst_n      in   1   synchronous, active-low reset
// - in_valid   in   1   operands a/b valid
// - in_ready   out  1   block can accept operands (high only in IDLE)
// - a          in   32  minuend, FP32
// - b          in   32  subtrahend, FP32
// - out_valid  out  1   result valid (high only in DONE)
// - out_ready  in   1   consumer accepts result
// - diff       out  32  result a - b, FP32
// BEHAVIOUR
// - Reset (rst_n==0 at posedge): state=IDLE, in_ready=1, out_valid=0, diff=32'h0, all internal registers cleared.
// - Reset has priority in every state and aborts any operation in flight; no result is produced for it.
// - Accept: when in_valid && in_ready at edge T, capture a, and b with its sign bit inverted (b' = -b). Hidden bit is always 1.
// - No special-case handling: exp 0 and exp 255 are treated as normal numbers; NaN, Inf and denormals are not recognised.
// - At capture: larger operand = the one with the larger exponent; on equal exponents, the one with the larger 24-bit mantissa.
// - Result sign = sign of the larger operand. On equal exponent and equal mantissa with opposite effective signs, the result is +0.
// - Working exponent = larger exponent. A = min(|ea-eb|, ALIGN_CLAMP).
// - FSM: IDLE -> ALIGN -> OP -> NORM -> DONE -> IDLE.
// - IDLE: accept operands; go to ALIGN if A>0, else go to OP.
// - ALIGN: A cycles; each cycle shifts the smaller mantissa right by 1 (truncating) and decrements the count. If the count hits ALIGN_CLAMP, the smaller mantissa is 0.
// - OP: 1 cycle; 25-bit sum = larger + smaller if effective signs are equal, otherwise larger - smaller (never negative).
// - NORM: N >= 1 cycles.
//   - sum[24]==1: shift right by 1 and exp+1 (1 cycle).
//   - sum[23]==1: no change (1 cycle).
//   - sum==0: result 32'h0000_0000 (1 cycle).
//   - otherwise: shift left by 1 and exp-1 per cycle until sum[23]==1 (N = leading-zero count above bit 23).
// - Exponent arithmetic is modulo 256: no overflow/underflow saturation and no flags.
// - DONE: diff = {sign, exp, sum[22:0]}; out_valid=1. diff is stable while out_valid && !out_ready.
// - On out_valid && out_ready: go to IDLE with out_valid=0. diff keeps its last value.
// - Latency: out_valid rises at T+2+A+N. in_ready is low from T+1 until the cycle after the result handshake.
// - in_valid is ignored outside IDLE. Operands do not need to stay stable after the accept edge.
// TESTING
// - 3.0-1.0: a=0x40400000 b=0x3F800000 -> diff=0x40000000; A=1, N=1; out_valid at T+4.
// - 1.0-(-1.0): a=0x3F800000 b=0xBF800000 -> 0x40000000 (carry path); out_valid at T+3.
// - 1.0-1.0: a=b=0x3F800000 -> 0x00000000 (+0); out_valid at T+3.
// - 1.5-1.25: a=0x3FC00000 b=0x3FA00000 -> 0x3E800000; N=2; out_valid at T+4.
// - Clamp: a=0x3F800000 b=0x30800000 (diff of exponents 30) -> 0x3F800000; A=25; out_valid at T+28.
// - Handshake/reset:
//   - Hold out_ready=0 for 5 cycles: diff and out_valid stay stable.
//   - Pulse in_valid during ALIGN: the pulse is ignored.
//   - rst_n=0 mid-ALIGN: next cycle out_valid=0, in_ready=1, diff=0.

Source files
------------

// File: rtl/fp32_sub_seq.sv
// Multi-cycle FP32 subtractor (a - b): truncating right-shift alignment and
// leading-one normalisation, one bit per cycle, with valid/ready on both sides.
module fp32_sub_seq #(
   parameter int ALIGN_CLAMP = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] diff
);

   localparam int CNT_W = $clog2(ALIGN_CLAMP + 1);
   localparam logic [CNT_W-1:0]  CLAMP_C = CNT_W'(ALIGN_CLAMP);
   localparam logic signed [8:0] CLAMP_S = 9'(ALIGN_CLAMP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_OP,
      S_NORM,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic             r_sign;
   logic [7:0]       r_exp;
   logic             r_eff_sub;
   logic [23:0]      r_big;
   logic [23:0]      r_small;
   logic [CNT_W-1:0] r_cnt;
   logic [24:0]      r_sum;
   logic [31:0]      r_diff;

   logic             w_sa;
   logic             w_sb;
   logic [7:0]       w_ea;
   logic [7:0]       w_eb;
   logic [23:0]      w_ma;
   logic [23:0]      w_mb;
   logic signed [8:0] w_ediff;
   logic signed [8:0] w_mag;
   logic             w_a_big;
   logic             w_zero_tie;
   logic             w_sign;
   logic [CNT_W-1:0] w_align;
   logic [7:0]       w_exp_inc;
   logic [7:0]       w_exp_dec;

   // Saturate the alignment distance; 25 shifts already empty a 24-bit mantissa.
   function automatic logic [CNT_W-1:0] sat_align(input logic signed [8:0] mag);
      if (mag >= CLAMP_S) begin
         return CLAMP_C;
      end
      return mag[CNT_W-1:0];
   endfunction

   // Subtraction is addition of b with its sign flipped.
   assign w_sa       = a[31];
   assign w_sb       = ~b[31];
   assign w_ea       = a[30:23];
   assign w_eb       = b[30:23];
   assign w_ma       = {1'b1, a[22:0]};
   assign w_mb       = {1'b1, b[22:0]};
   assign w_ediff    = $signed({1'b0, w_ea}) - $signed({1'b0, w_eb});
   assign w_a_big    = (w_ea > w_eb) || ((w_ea == w_eb) && (w_ma >= w_mb));
   assign w_mag      = w_a_big ? w_ediff : -w_ediff;
   assign w_align    = sat_align(w_mag);
   assign w_zero_tie = (w_ea == w_eb) && (w_ma == w_mb) && (w_sa != w_sb);
   assign w_sign     = w_zero_tie ? 1'b0 : (w_a_big ? w_sa : w_sb);
   assign w_exp_inc  = r_exp + 8'd1;
   assign w_exp_dec  = r_exp - 8'd1;

   assign diff = r_diff;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = (w_align != '0) ? S_ALIGN : S_OP;
            end
         end
         S_ALIGN: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = S_OP;
            end
         end
         S_OP: begin
            w_state_nxt = S_NORM;
         end
         S_NORM: begin
            // A left shift that lands the leading one on bit 23 finishes in the same cycle.
            if (r_sum[24] || r_sum[23] || (r_sum == '0) || r_sum[22]) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sign    <= 1'b0;
         r_exp     <= '0;
         r_eff_sub <= 1'b0;
         r_big     <= '0;
         r_small   <= '0;
         r_cnt     <= '0;
         r_sum     <= '0;
         r_diff    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sign    <= w_sign;
                  r_exp     <= w_a_big ? w_ea : w_eb;
                  r_eff_sub <= w_sa ^ w_sb;
                  r_big     <= w_a_big ? w_ma : w_mb;
                  r_small   <= w_a_big ? w_mb : w_ma;
                  r_cnt     <= w_align;
               end
            end
            S_ALIGN: begin
               r_small <= r_small >> 1;
               r_cnt   <= r_cnt - CNT_W'(1);
            end
            S_OP: begin
               if (r_eff_sub) begin
                  r_sum <= {1'b0, r_big} - {1'b0, r_small};
               end else begin
                  r_sum <= {1'b0, r_big} + {1'b0, r_small};
               end
            end
            S_NORM: begin
               if (r_sum[24]) begin
                  r_sum  <= r_sum >> 1;
                  r_exp  <= w_exp_inc;
                  r_diff <= {r_sign, w_exp_inc, r_sum[23:1]};
               end else if (r_sum[23]) begin
                  r_diff <= {r_sign, r_exp, r_sum[22:0]};
               end else if (r_sum == '0) begin
                  r_diff <= '0;
               end else begin
                  r_sum <= {r_sum[23:0], 1'b0};
                  r_exp <= w_exp_dec;
                  if (r_sum[22]) begin
                     r_diff <= {r_sign, w_exp_dec, r_sum[21:0], 1'b0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_sub_seq.sv
// Scoreboard bench for fp32_sub_seq: directed vectors push expected result and
// due cycle; an independent monitor checks every presented result.
module tb_fp32_sub_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   in_result = 0;

   fp32_sub_seq #(.ALIGN_CLAMP(25)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff     (diff)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: samples just after the falling edge, so it sees the inputs the DUT
   // will see at the next rising edge.
   always begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected-output actual=%h required=no result", diff);
         end else begin
            if (!in_result) begin
               chk("latency", 32'(cyc + 1), 32'(q[0].due));
               chk("in_ready-low-in-done", {31'd0, in_ready}, 32'd0);
               in_result = 1;
            end
            chk("diff", diff, q[0].d);
            if (out_ready) begin
               void'(q.pop_front());
               in_result = 0;
            end
         end
      end
   end

   // Called at a falling edge; the operands are accepted at the next rising edge.
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] exp_d, input int lat, input bit push);
      exp_t e;
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL issue-timeout actual=in_ready 0 required=1");
         return;
      end
      a = ia;
      b = ib;
      in_valid = 1'b1;
      if (push) begin
         e.d = exp_d;
         e.due = cyc + 1 + lat;
         q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      a = 32'h0;
      b = 32'h0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || !in_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (q.size() != 0 || !in_ready) begin
         bad++;
         $display("FAIL drain-timeout actual=%0d pending required=0", q.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = 32'h0;
      b = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset-in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset-out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset-diff", diff, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(32'h40400000, 32'h3F800000, 32'h40000000, 4, 1); // 3.0 - 1.0
      issue(32'h3F800000, 32'hBF800000, 32'h40000000, 3, 1); // 1.0 - (-1.0), carry
      issue(32'h3F800000, 32'h3F800000, 32'h00000000, 3, 1); // 1.0 - 1.0 = +0
      issue(32'h3FC00000, 32'h3FA00000, 32'h3E800000, 4, 1); // 1.5 - 1.25, N=2
      issue(32'h3FA00000, 32'h3FC00000, 32'hBE800000, 4, 1); // 1.25 - 1.5, b' larger
      issue(32'h3F800000, 32'h40400000, 32'hC0000000, 4, 1); // 1.0 - 3.0
      issue(32'h40000000, 32'hC0400000, 32'h40A00000, 3, 1); // 2.0 - (-3.0)
      issue(32'h40000000, 32'h3F800001, 32'h3F800000, 4, 1); // truncated alignment
      issue(32'h7F800000, 32'h7F000000, 32'h7F000000, 4, 1); // exp 255 as normal
      issue(32'h7F800000, 32'hFF800000, 32'h00000000, 3, 1); // exponent wraps to 0
      issue(32'h3F800000, 32'h30800000, 32'h3F800000, 28, 1); // clamped alignment
      drain();

      // Stall the consumer: result must hold for five cycles.
      out_ready = 1'b0;
      issue(32'h40400000, 32'h3F800000, 32'h40000000, 4, 1);
      for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold-out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold-diff", diff, 32'h40000000);
      end
      out_ready = 1'b1;
      drain();

      // in_valid pulse during alignment must be ignored.
      issue(32'h3F800000, 32'h30800000, 32'h3F800000, 28, 1);
      repeat (3) @(negedge clk);
      chk("align-in_ready", {31'd0, in_ready}, 32'd0);
      a = 32'h40400000;
      b = 32'h3F800000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      drain();
      repeat (8) @(negedge clk);
      chk("idle-after-pulse", {31'd0, in_ready}, 32'd1);

      // Reset in the middle of alignment aborts the operation.
      issue(32'h3F800000, 32'h30800000, 32'h3F800000, 28, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset-out_valid", {31'd0, out_valid}, 32'd0);
      chk("midreset-in_ready", {31'd0, in_ready}, 32'd1);
      chk("midreset-diff", diff, 32'h0);
      rst_n = 1'b1;
      repeat (35) @(negedge clk);
      chk("post-reset-idle", {31'd0, in_ready}, 32'd1);
      issue(32'h3FC00000, 32'h3FA00000, 32'h3E800000, 4, 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
